fpga_spi_master: RTL and testbench
==================================

# fpga_spi_master

FPGA-side SPI master that issues register-access frames to an external SPI register slave, using the same frame as the DSP-to-FPGA register port. Each frame is one R/W bit, a 7-bit address and 8 data bits, MSB first, with an optional 17th status clock. It sits between an internal control sequencer (start/done handshake) and the board-level SPI pins. The SPI clock is derived from the system clock by a programmable divider.

## Interface
Parameters:
- CLK_DIV, default 4: SCK half-period in clk cycles; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- rw  in  1  1 = read, 0 = write; latched on accept.
- addr  in  7  register address; latched on accept.
- data_w  in  8  write data; latched on accept, ignored for reads.
- data_r  out  8  read data; valid from the done pulse until the next accept.
- status  out  1  status bit captured on the 17th clock (STATUS_EN only, else 0).
- busy  out  1  high from the cycle after accept through the done cycle.
- done  out  1  one-cycle pulse at the end of the frame.
- SPI_SSEL  out  1  active-low slave select.
- SPI_SCK  out  1  SPI clock, idle low.
- SPI_MOSI  out  1  master out.
- SPI_MISO  in  1  master in; synchronized with a 2-flop synchronizer before use.

## Operation
- Reset values: SPI_SSEL=1, SPI_SCK=0, SPI_MOSI=0, data_r=0, status=0, busy=0, done=0, state=IDLE.
- Frame bit order: b0 = rw, b1..b7 = addr[6:0] MSB first, b8..b15 = data. During the data phase of a read, MOSI = 0.
- The bit count NB is 16, or 17 with STATUS_EN.
- States:
  - IDLE: waits for start. On start, latches the inputs into a 16-bit shift register and goes to SETUP.
  - SETUP: SSEL=0, MOSI=b0, SCK=0 for CLK_DIV cycles, then goes to SHIFT.
  - SHIFT: generates NB SCK periods, each CLK_DIV high and then CLK_DIV low.
    - On rising edges 2..16, MOSI advances to the next bit. On rising edge 17 (STATUS_EN), MOSI = 0.
    - On each falling edge, the master samples synchronized MISO. Falling edges 9..16 shift into read data, MSB first, for reads only. Falling edge 17 captures status.
    - After the last falling edge, goes to HOLD.
  - HOLD: SCK=0, SSEL stays 0 for CLK_DIV cycles, then SSEL=1 and MOSI=0. Goes to GAP.
  - GAP: SSEL stays high for CLK_DIV cycles. On the last GAP cycle, data_r (reads only; writes leave data_r unchanged) and status update, done=1, and the state returns to IDLE.
- start is ignored while busy. start in the same cycle as done is also ignored; a new start is accepted from the cycle after done.
- rst asserted mid-frame: all outputs return to their reset values immediately. The partial frame is abandoned with no done pulse.
- MISO synchronizer latency (2 clk) must be less than CLK_DIV + 1 cycles after the slave's rising-edge update. Hence CLK_DIV ≥ 2 is required for correct read data; CLK_DIV = 1 is legal for write-only use.

## Timing
- Accept to busy: 1 cycle.
- Frame length from accept to done: CLK_DIV*(3 + 2*NB) cycles.
  - CLK_DIV=4, NB=16: 140 cycles.
  - CLK_DIV=4, NB=17: 148 cycles.
- SSEL low to first SCK rise: CLK_DIV cycles. Last SCK fall to SSEL high: CLK_DIV cycles. Minimum SSEL high between frames: CLK_DIV+1 cycles.
- MOSI changes only with SCK rising (or on SSEL fall), so it is stable CLK_DIV cycles before and after every SCK falling edge.
- Divider counter is 8 bits and reloads to CLK_DIV-1 on each phase change. Bit counter is 5 bits and counts 0..NB-1 without wrap.

## Configuration
- FPGA_SPI_STATUS_EN defined: NB=17. The 17th SCK period is generated, status is captured on its falling edge, and the frame is 8 clk longer at CLK_DIV=4.
- FPGA_SPI_STATUS_EN undefined: NB=16. status is tied to 0 and no 17th clock is generated.

## Test plan
- Write, CLK_DIV=4: rw=0, addr=0x5A, data_w=0x3C. Slave model captures MOSI stream 0_1011010_00111100 on SCK falls. done occurs at 140 cycles after accept. data_r is unchanged.
- Read: rw=1, addr=0x11. Slave drives 0xA5 on rising edges 9..16. Master returns data_r=0xA5 with done, and MOSI=0 during the data phase.
- Busy rejection: second start pulse 10 cycles after accept, and another in the done cycle. Exactly one frame is issued, and the next start one cycle after done is accepted.
- Reset mid-frame: assert rst during SCK period 6. SSEL=1, SCK=0, MOSI=0 in the same cycle, no done pulse, and a following frame completes normally.
- STATUS_EN: write with data_w=0x00, slave drives MISO=1 on rising edge 17. Result: status=1, 17 SCK periods, and done at 148 cycles.
- CLK_DIV=2 read of 0xFF and then of 0x00. Both data_r values are correct, and the SCK high and low times are each exactly 2 cycles.

Source files
------------

// File: rtl/fpga_spi_master.sv
// SPI master issuing R/W + 7-bit address + 8-bit data register frames, MSB first.
// Define FPGA_SPI_STATUS_EN to add a 17th SCK period that captures a status bit.
module fpga_spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] data_w,
    output logic [7:0] data_r,
    output logic       status,
    output logic       busy,
    output logic       done,
    output logic       SPI_SSEL,
    output logic       SPI_SCK,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO
);

`ifdef FPGA_SPI_STATUS_EN
    localparam int unsigned NB = 17;
`else
    localparam int unsigned NB = 16;
`endif
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(NB - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t      state_q;
    logic [7:0]  div_q;
    logic [4:0]  bit_q;
    logic [14:0] tx_q;
    logic [7:0]  rx_q;
    logic        rw_q;
    logic [7:0]  data_r_q;
    logic        busy_q;
    logic        done_q;
    logic        ssel_q;
    logic        sck_q;
    logic        mosi_q;
    logic [1:0]  miso_sync_q;
    logic        miso_s;
    logic        finish_d;
`ifdef FPGA_SPI_STATUS_EN
    logic        stat_cap_q;
    logic        status_q;
`endif

    assign miso_s = miso_sync_q[1];

    // The cycle that carries done: last GAP cycle, or GAP entry when GAP is one cycle long.
    assign finish_d = ((state_q == HOLD) && (div_q == 8'd0) && (CLK_DIV == 1)) ||
                      ((state_q == GAP)  && (div_q == 8'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= 8'd0;
            bit_q       <= 5'd0;
            tx_q        <= 15'd0;
            rx_q        <= 8'd0;
            rw_q        <= 1'b0;
            data_r_q    <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ssel_q      <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            miso_sync_q <= 2'b00;
`ifdef FPGA_SPI_STATUS_EN
            stat_cap_q  <= 1'b0;
            status_q    <= 1'b0;
`endif
        end else begin
            // NOTE: every register here uses <=, so all decisions below see pre-edge values.
            miso_sync_q <= {miso_sync_q[0], SPI_MISO};
            done_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        tx_q    <= {addr, (rw ? 8'h00 : data_w)};
                        rw_q    <= rw;
                        mosi_q  <= rw;
                        ssel_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        div_q   <= DIV_LAST;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_q == 8'd0) begin
                        sck_q   <= 1'b1;
                        bit_q   <= 5'd0;
                        div_q   <= DIV_LAST;
                        state_q <= SHIFT;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                SHIFT: begin
                    // Sample one cycle after the fall so the synchronized MISO has settled.
                    if (!sck_q && (div_q == DIV_LAST)) begin
                        if (rw_q && (bit_q >= 5'd8) && (bit_q <= 5'd15))
                            rx_q <= {rx_q[6:0], miso_s};
`ifdef FPGA_SPI_STATUS_EN
                        if (bit_q == 5'd16)
                            stat_cap_q <= miso_s;
`endif
                    end
                    if (div_q == 8'd0) begin
                        div_q <= DIV_LAST;
                        if (sck_q) begin
                            sck_q <= 1'b0;
                        end else if (bit_q == BIT_LAST) begin
                            state_q <= HOLD;
                        end else begin
                            sck_q <= 1'b1;
                            bit_q <= bit_q + 5'd1;
                            if (bit_q < 5'd15) begin
                                mosi_q <= tx_q[14];
                                tx_q   <= {tx_q[13:0], 1'b0};
                            end else begin
                                mosi_q <= 1'b0;
                            end
                        end
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                HOLD: begin
                    if (div_q == 8'd0) begin
                        ssel_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        div_q   <= DIV_LAST;
                        state_q <= GAP;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                GAP: begin
                    if (div_q == 8'd0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (finish_d) begin
                done_q <= 1'b1;
                if (rw_q)
                    data_r_q <= rx_q;
`ifdef FPGA_SPI_STATUS_EN
                status_q <= stat_cap_q;
`endif
            end
        end
    end

    assign data_r   = data_r_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign SPI_SSEL = ssel_q;
    assign SPI_SCK  = sck_q;
    assign SPI_MOSI = mosi_q;
`ifdef FPGA_SPI_STATUS_EN
    assign status   = status_q;
`else
    assign status   = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_spi_master.sv
// Directed bench for fpga_spi_master: one instance at CLK_DIV=4, one at CLK_DIV=2,
// sharing a clk-sampled SPI slave model selected by sel.
module tb_fpga_spi_master;

`ifdef FPGA_SPI_STATUS_EN
    localparam int NB = 17, LAT4 = 148, LAT2 = 74, STAT_EXP = 1;
`else
    localparam int NB = 16, LAT4 = 140, LAT2 = 70, STAT_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic start_x = 1'b0;
    logic rw = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] data_w = 8'd0;
    logic miso = 1'b0;

    logic start4, start2;
    logic [7:0] data_r4, data_r2;
    logic status4, status2, busy4, busy2, done4, done2;
    logic ssel4, ssel2, sck4, sck2, mosi4, mosi2;
    logic [7:0] data_r_m;
    logic status_m, busy_m, done_m, ssel_m, sck_m, mosi_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign start4 = start_x & ~sel;
    assign start2 = start_x & sel;
    assign data_r_m = sel ? data_r2 : data_r4;
    assign status_m = sel ? status2 : status4;
    assign busy_m   = sel ? busy2   : busy4;
    assign done_m   = sel ? done2   : done4;
    assign ssel_m   = sel ? ssel2   : ssel4;
    assign sck_m    = sel ? sck2    : sck4;
    assign mosi_m   = sel ? mosi2   : mosi4;

    fpga_spi_master #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .rw(rw), .addr(addr), .data_w(data_w),
        .data_r(data_r4), .status(status4), .busy(busy4), .done(done4),
        .SPI_SSEL(ssel4), .SPI_SCK(sck4), .SPI_MOSI(mosi4), .SPI_MISO(miso)
    );

    fpga_spi_master #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .rw(rw), .addr(addr), .data_w(data_w),
        .data_r(data_r2), .status(status2), .busy(busy2), .done(done2),
        .SPI_SSEL(ssel2), .SPI_SCK(sck2), .SPI_MOSI(mosi2), .SPI_MISO(miso)
    );

    // Slave model: observes pins at negedge, drives MISO half a cycle after each SCK rise.
    logic [7:0]  slave_data = 8'h00;
    logic        slave_status = 1'b0;
    logic        sck_p = 1'b0;
    logic        ssel_p = 1'b1;
    logic [15:0] cap = 16'h0;
    logic        mosi_bad = 1'b0;
    int rise_cnt = 0, fall_cnt = 0, frames = 0, run = 0;
    int hi_min = 255, hi_max = 0, lo_min = 255, lo_max = 0;

    always @(negedge clk) begin
        sck_p  <= sck_m;
        ssel_p <= ssel_m;
        if (ssel_p && !ssel_m) begin
            rise_cnt <= 0;
            fall_cnt <= 0;
            cap      <= 16'h0;
            mosi_bad <= 1'b0;
            run      <= 0;
            hi_min   <= 255;
            hi_max   <= 0;
            lo_min   <= 255;
            lo_max   <= 0;
            frames   <= frames + 1;
        end else if (!ssel_m) begin
            if (sck_m && !sck_p) begin
                rise_cnt <= rise_cnt + 1;
                if (rise_cnt > 0) begin
                    if (run < lo_min) lo_min <= run;
                    if (run > lo_max) lo_max <= run;
                end
                run <= 1;
                if (rise_cnt >= 8 && rise_cnt <= 15)
                    miso <= slave_data[3'(15 - rise_cnt)];
                else if (rise_cnt == 16)
                    miso <= slave_status;
            end else if (!sck_m && sck_p) begin
                fall_cnt <= fall_cnt + 1;
                if (fall_cnt < 16) cap <= {cap[14:0], mosi_m};
                if (run < hi_min) hi_min <= run;
                if (run > hi_max) hi_max <= run;
                run <= 1;
            end else begin
                run <= run + 1;
            end
            if (rise_cnt >= 9 && rise_cnt <= 16 && mosi_m)
                mosi_bad <= 1'b1;
        end else begin
            miso <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one frame on the selected DUT; lat counts clk edges from the accept edge
    // (inclusive) to the edge that raises done.
    task automatic frame(input logic r, input logic [6:0] a, input logic [7:0] dw,
                         input int poke_at, input bit start_on_done, output int lat);
        @(negedge clk);
        rw = r; addr = a; data_w = dw; start_x = 1'b1;
        @(negedge clk);
        lat = 1;
        start_x = 1'b0;
        check("busy_after_accept", 32'(busy_m), 32'd1);
        while (!done_m && lat < 1000) begin
            start_x = (lat == poke_at);
            @(negedge clk);
            lat++;
        end
        start_x = start_on_done;
    endtask

    int lat, lat2, f0, done_seen, wait_cnt;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ssel",   32'(ssel4),   32'd1);
        check("rst_sck",    32'(sck4),    32'd0);
        check("rst_mosi",   32'(mosi4),   32'd0);
        check("rst_data_r", 32'(data_r4), 32'd0);
        check("rst_busy",   32'(busy4),   32'd0);
        check("rst_done",   32'(done4),   32'd0);
        check("rst_status", 32'(status4), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Read 0xA5 from 0x11; data_w must not leak onto MOSI.
        slave_data = 8'hA5;
        frame(1'b1, 7'h11, 8'hFF, 0, 1'b0, lat);
        check("rd_lat",      32'(lat),      32'(LAT4));
        check("rd_data",     32'(data_r_m), 32'hA5);
        check("rd_mosi_cap", 32'(cap),      32'h9100);
        check("rd_mosi_dat", 32'(mosi_bad), 32'd0);
        check("rd_periods",  32'(rise_cnt), 32'(NB));

        // Write 0x3C to 0x5A; data_r keeps the previous read value.
        frame(1'b0, 7'h5A, 8'h3C, 0, 1'b0, lat);
        check("wr_lat",    32'(lat),      32'(LAT4));
        check("wr_cap",    32'(cap),      32'h5A3C);
        check("wr_data_r", 32'(data_r_m), 32'hA5);

        // Starts at +10 cycles and in the done cycle are dropped; the next cycle's start wins.
        f0 = frames;
        frame(1'b0, 7'h22, 8'h81, 10, 1'b1, lat);
        check("busy_lat", 32'(lat), 32'(LAT4));
        check("busy_cap", 32'(cap), 32'h2281);
        frame(1'b0, 7'h33, 8'h44, 0, 1'b0, lat2);
        check("after_done_lat", 32'(lat2),       32'(LAT4));
        check("after_done_cap", 32'(cap),        32'h3344);
        check("frame_count",    32'(frames - f0), 32'd2);

        // Reset during SCK period 6 (MOSI = addr[2] = 1 there).
        @(negedge clk);
        rw = 1'b0; addr = 7'h7F; data_w = 8'hFF; start_x = 1'b1;
        @(negedge clk);
        start_x = 1'b0;
        wait_cnt = 0;
        while (!(rise_cnt == 6 && sck_m) && wait_cnt < 500) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("mid_sck_high", 32'(sck_m),  32'd1);
        check("mid_mosi_hi",  32'(mosi_m), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ssel", 32'(ssel_m), 32'd1);
        check("mid_rst_sck",  32'(sck_m),  32'd0);
        check("mid_rst_mosi", 32'(mosi_m), 32'd0);
        check("mid_rst_busy", 32'(busy_m), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (done_m) done_seen++;
        end
        check("mid_no_done", 32'(done_seen), 32'd0);
        frame(1'b0, 7'h5A, 8'h3C, 0, 1'b0, lat);
        check("post_rst_lat", 32'(lat), 32'(LAT4));
        check("post_rst_cap", 32'(cap), 32'h5A3C);

        // Status clock: slave drives 1 on rise 17 if that rise exists.
        slave_status = 1'b1;
        frame(1'b0, 7'h0F, 8'h00, 0, 1'b0, lat);
        check("st_lat",     32'(lat),      32'(LAT4));
        check("st_status",  32'(status_m), 32'(STAT_EXP));
        check("st_periods", 32'(rise_cnt), 32'(NB));
        check("st_cap",     32'(cap),      32'h0F00);
        slave_status = 1'b0;

        // CLK_DIV=2 reads of 0xFF and 0x00 with exact 2-cycle SCK halves.
        sel = 1'b1;
        repeat (2) @(negedge clk);
        slave_data = 8'hFF;
        frame(1'b1, 7'h01, 8'h00, 0, 1'b0, lat);
        check("d2_ff_lat",  32'(lat),      32'(LAT2));
        check("d2_ff_data", 32'(data_r_m), 32'hFF);
        check("d2_hi_min",  32'(hi_min),   32'd2);
        check("d2_hi_max",  32'(hi_max),   32'd2);
        check("d2_lo_min",  32'(lo_min),   32'd2);
        check("d2_lo_max",  32'(lo_max),   32'd2);
        slave_data = 8'h00;
        frame(1'b1, 7'h02, 8'hFF, 0, 1'b0, lat);
        check("d2_00_lat",  32'(lat),      32'(LAT2));
        check("d2_00_data", 32'(data_r_m), 32'h00);
        check("d2_00_cap",  32'(cap),      32'h8200);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
